// File: rtl/axis_lane_unpacker_pkg.sv
// ---------------------------------------------------------------------------
// axis_lane_unpacker_pkg
//   Shared definitions for the AXI-Stream lane unpacker that feeds the
//   double-precision PE stage: element width, lane count, controller state
//   encoding and the PE opcode type.
//   Optional build macro used by the top: UNPACK_STATS_EN.
// ---------------------------------------------------------------------------
package axis_lane_unpacker_pkg;

    // Element width of the double-precision PE datapath.
    localparam int unsigned dwidth_double = 64;

    // Elements carried by one 512-bit stream beat.
    localparam int unsigned LANES = 512 / dwidth_double;

    // IDLE: buffer empty. DRAIN: buffer holds a beat with lanes still to emit.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // PE opcode.
    typedef logic [1:0] op_t;

endpackage

// File: rtl/axis_lane_unpacker_prio_enc.sv
// ---------------------------------------------------------------------------
// lane_prio_enc
//   Combinational lowest-set-bit encoder over the pending lane mask.
//   Ports:
//     req  in   NUM_LANES  pending lane mask
//     idx  out  IDX_W      index of the lowest set bit (0 when req == 0)
//     clr  out  NUM_LANES  one-hot mask of that bit (0 when req == 0)
//     any  out  1          req has at least one bit set
// ---------------------------------------------------------------------------
module lane_prio_enc
    import axis_lane_unpacker_pkg::*;
#(
    parameter  int unsigned NUM_LANES = LANES,
    localparam int unsigned IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic [NUM_LANES-1:0] req,
    output logic [IDX_W-1:0]     idx,
    output logic [NUM_LANES-1:0] clr,
    output logic                 any
);

    logic found;

    always_comb begin
        idx   = '0;
        clr   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (req[k] && !found) begin
                found  = 1'b1;
                idx    = IDX_W'(k);
                clr[k] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/axis_lane_unpacker.sv
// ---------------------------------------------------------------------------
// axis_lane_unpacker
//   Accepts 512-bit AXI-Stream beats of eight 64-bit elements and emits the
//   kept lanes one per cycle, lowest lane first, into the PE's 64-bit
//   data/valid input. Latches the opcode at the first beat of each packet and
//   flags the final element of a packet. The scheduler's stall freezes
//   emission; there is no downstream ready.
//   Optional build macro: UNPACK_STATS_EN adds saturating element/drop
//   counters (stat_elems, stat_drops).
//   Ports:
//     clk, rst (async, active-low)
//     s_axis_tdata/tkeep/tlast/tvalid in, s_axis_tready out
//     cfg_op  opcode sampled at a packet's first beat
//     stall   freeze emission
//     out1, t_valid_out1, op_out, out_last   registered PE-side outputs
//     stat_elems, stat_drops                 (UNPACK_STATS_EN only)
// ---------------------------------------------------------------------------
module axis_lane_unpacker
    import axis_lane_unpacker_pkg::*;
#(
    parameter  int unsigned IN_WIDTH  = 512,
    parameter  int unsigned OUT_WIDTH = dwidth_double,
    localparam int unsigned LANES     = IN_WIDTH / OUT_WIDTH,
    localparam int unsigned IDX_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic [LANES-1:0]     s_axis_tkeep,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  op_t                  cfg_op,
    input  logic                 stall,
    output logic [OUT_WIDTH-1:0] out1,
    output logic                 t_valid_out1,
    output op_t                  op_out,
    output logic                 out_last
`ifdef UNPACK_STATS_EN
    ,
    output logic [31:0]          stat_elems,
    output logic [31:0]          stat_drops
`endif
);

    state_t                 state;
    logic [IN_WIDTH-1:0]    data_q;
    logic [LANES-1:0]       rem;
    logic                   last_flag;
    logic                   pkt_start;

    logic [IDX_W-1:0]       lane_idx;
    logic [LANES-1:0]       lane_clr;
    logic                   lane_any;
    logic [LANES-1:0]       rem_after;
    logic [OUT_WIDTH-1:0]   lane_data;
    logic                   emit;
    logic                   single;
    logic                   accept;

    lane_prio_enc #(
        .NUM_LANES (LANES)
    ) u_prio_enc (
        .req (rem),
        .idx (lane_idx),
        .clr (lane_clr),
        .any (lane_any)
    );

    always_comb begin
        lane_data = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (lane_idx == IDX_W'(k)) begin
                lane_data = data_q[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign rem_after = rem & ~lane_clr;
    assign emit      = lane_any && !stall;
    // Exactly one lane left: it leaves on this edge, so the next beat can
    // load on the same edge without a bubble.
    assign single    = lane_any && (rem_after == '0);

    assign s_axis_tready = rst && ((state == IDLE) || (single && !stall));
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            data_q       <= '0;
            rem          <= '0;
            last_flag    <= 1'b0;
            pkt_start    <= 1'b1;
            out1         <= '0;
            t_valid_out1 <= 1'b0;
            op_out       <= '0;
            out_last     <= 1'b0;
        end else begin
            if (emit) begin
                out1         <= lane_data;
                t_valid_out1 <= 1'b1;
                out_last     <= last_flag && (rem_after == '0);
            end else begin
                t_valid_out1 <= 1'b0;
                out_last     <= 1'b0;
            end

            // Acceptance only happens with at most one lane pending, which
            // the emission above consumes, so the load simply overwrites rem.
            if (accept) begin
                data_q    <= s_axis_tdata;
                rem       <= s_axis_tkeep;
                last_flag <= s_axis_tlast;
                state     <= (s_axis_tkeep != '0) ? DRAIN : IDLE;
                if (pkt_start) begin
                    op_out <= cfg_op;
                end
                pkt_start <= s_axis_tlast;
            end else if (emit) begin
                rem   <= rem_after;
                state <= (rem_after != '0) ? DRAIN : IDLE;
            end
        end
    end

`ifdef UNPACK_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_elems <= '0;
            stat_drops <= '0;
        end else begin
            if (emit && (stat_elems != '1)) begin
                stat_elems <= stat_elems + 32'd1;
            end
            if (accept && (s_axis_tkeep == '0) && (stat_drops != '1)) begin
                stat_drops <= stat_drops + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_lane_unpacker.sv
module tb_axis_lane_unpacker;

    logic         clk;
    logic         rst;
    logic [511:0] s_axis_tdata;
    logic [7:0]   s_axis_tkeep;
    logic         s_axis_tlast;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [1:0]   cfg_op;
    logic         stall;
    logic [63:0]  out1;
    logic         t_valid_out1;
    logic [1:0]   op_out;
    logic         out_last;
`ifdef UNPACK_STATS_EN
    logic [31:0]  stat_elems;
    logic [31:0]  stat_drops;
`endif

    axis_lane_unpacker #(
        .IN_WIDTH  (512),
        .OUT_WIDTH (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .cfg_op        (cfg_op),
        .stall         (stall),
        .out1          (out1),
        .t_valid_out1  (t_valid_out1),
        .op_out        (op_out),
        .out_last      (out_last)
`ifdef UNPACK_STATS_EN
        ,
        .stat_elems    (stat_elems),
        .stat_drops    (stat_drops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of elements still owed from the buffered beat.
    logic [63:0] mq[$];
    logic [63:0] exp_out1;
    logic        exp_valid;
    logic        exp_last;
    logic [1:0]  exp_op;
    logic        m_pkt_start;
    logic        m_last;
    int unsigned m_elems;
    int unsigned m_drops;
    logic        last_acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_out1    = '0;
        exp_valid   = 1'b0;
        exp_last    = 1'b0;
        exp_op      = '0;
        m_pkt_start = 1'b1;
        m_last      = 1'b0;
        m_elems     = 0;
        m_drops     = 0;
    endtask

    task automatic check_outputs();
        check_eq("out1", out1, exp_out1);
        check_eq("t_valid_out1", {63'd0, t_valid_out1}, {63'd0, exp_valid});
        check_eq("out_last", {63'd0, out_last}, {63'd0, exp_last});
        check_eq("op_out", {62'd0, op_out}, {62'd0, exp_op});
`ifdef UNPACK_STATS_EN
        check_eq("stat_elems", {32'd0, stat_elems}, {32'd0, m_elems});
        check_eq("stat_drops", {32'd0, stat_drops}, {32'd0, m_drops});
`endif
    endtask

    // One clock: drive at the falling edge, check ready, let the rising edge
    // happen, update the model, then check registered outputs.
    task automatic cycle(input logic v, input logic [511:0] d, input logic [7:0] k,
                         input logic l, input logic [1:0] op, input logic st);
        logic exp_ready;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        cfg_op        = op;
        stall         = st;
        #1;
        exp_ready = (mq.size() == 0) || (mq.size() == 1 && !st);
        check_eq("tready", {63'd0, s_axis_tready}, {63'd0, exp_ready});
        last_acc = v && exp_ready;
        @(posedge clk);
        if (!st && mq.size() > 0) begin
            exp_out1  = mq.pop_front();
            exp_valid = 1'b1;
            exp_last  = m_last && (mq.size() == 0);
            m_elems++;
        end else begin
            exp_valid = 1'b0;
            exp_last  = 1'b0;
        end
        if (last_acc) begin
            for (int i = 0; i < 8; i++)
                if (k[i]) mq.push_back(d[i*64 +: 64]);
            m_last = l;
            if (m_pkt_start) exp_op = op;
            m_pkt_start = l;
            if (k == 8'h00) m_drops++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 8'h00, 1'b0, 2'b00, st);
    endtask

    task automatic send_beat(input logic [511:0] d, input logic [7:0] k,
                             input logic l, input logic [1:0] op);
        int tries;
        tries = 0;
        last_acc = 1'b0;
        while (!last_acc && tries < 40) begin
            cycle(1'b1, d, k, l, op, 1'b0);
            tries++;
        end
        if (!last_acc) check_eq("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic apply_reset();
        rst           = 1'b0;
        s_axis_tvalid = 1'b0;
        stall         = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_eq("tready_in_reset", {63'd0, s_axis_tready}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("tready_after_reset", {63'd0, s_axis_tready}, 64'd1);
    endtask

    function automatic logic [511:0] lanes_from(input int base);
        logic [511:0] d;
        for (int i = 0; i < 8; i++) d[i*64 +: 64] = 64'(base + i);
        return d;
    endfunction

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [511:0] d;
        logic [7:0]   k;
        rst           = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        cfg_op        = '0;
        stall         = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Full beat, lanes 1..8.
        send_beat(lanes_from(1), 8'hFF, 1'b1, 2'b01);
        idle(9, 1'b0);

        // Back-to-back full beats with tvalid held.
        send_beat(lanes_from(11), 8'hFF, 1'b0, 2'b10);
        send_beat(lanes_from(21), 8'hFF, 1'b1, 2'b11);
        idle(9, 1'b0);

        // Sparse mask, lanes 100+k.
        send_beat(lanes_from(100), 8'b1010_0100, 1'b1, 2'b10);
        idle(5, 1'b0);

        // Stall for 3 cycles after element 2.
        send_beat(lanes_from(200), 8'hFF, 1'b1, 2'b01);
        idle(2, 1'b0);
        idle(3, 1'b1);
        idle(8, 1'b0);

        // Zero-keep packet, then a new packet with opcode 00.
        send_beat(lanes_from(300), 8'h00, 1'b1, 2'b11);
        send_beat(lanes_from(310), 8'h0F, 1'b1, 2'b00);
        idle(6, 1'b0);

        // Reset in the middle of draining.
        send_beat(lanes_from(400), 8'hFF, 1'b1, 2'b10);
        idle(3, 1'b0);
        apply_reset();
        idle(10, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 800; n++) begin
            d = rand_data();
            case ($urandom_range(0, 5))
                0:       k = 8'h00;
                1:       k = 8'hFF;
                default: k = 8'($urandom);
            endcase
            cycle($urandom_range(0, 3) != 0, d, k, $urandom_range(0, 2) == 0,
                  2'($urandom), $urandom_range(0, 4) == 0);
        end
        idle(12, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_lane_unpacker.md
Name: axis_lane_unpacker

Overview:
- Upstream feeder for the double-precision PE stage.
- Accepts 512-bit AXI-Stream beats carrying eight 64-bit elements and serialises the kept lanes, one per cycle, into the PE's 64-bit data/valid input.
- Latches the per-packet opcode and marks the last element of each packet.
- Has no downstream ready, because the PE has none; a stall input from the scheduler freezes emission.

Parameters:
- IN_WIDTH, 512: input stream width in bits.
- OUT_WIDTH, 64: element width; equals dwidth_double.
- LANES, IN_WIDTH/OUT_WIDTH (8): derived, not overridable.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  IN_WIDTH  packed elements; lane k = bits [64k+63:64k].
- s_axis_tkeep  in  LANES  lane-granular keep mask.
- s_axis_tlast  in  1  beat is the last of its packet.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when tvalid&tready at a rising edge.
- cfg_op  in  2  opcode, sampled at the first beat of a packet.
- stall  in  1  freeze emission.
- out1  out  OUT_WIDTH  element to PE inp1.
- t_valid_out1  out  1  element valid, to PE t_valid_inp1.
- op_out  out  2  opcode for the current packet, to PE op.
- out_last  out  1  qualifies the final element of a packet.

Behaviour:
- Reset (rst low, asynchronous):
  - buffer empty, mask 0, pkt_start=1;
  - out1=0, t_valid_out1=0, op_out=0, out_last=0;
  - s_axis_tready forced 0 while rst is low, then 1 from the first cycle after release.
- State machine:
  - IDLE: buffer empty, tready=1.
  - DRAIN: buffer holds a beat with remaining mask rem != 0.
- Acceptance:
  - A beat accepted at edge N loads data, rem=tkeep and last_flag=tlast.
  - If pkt_start, op_out<=cfg_op at edge N and pkt_start clears; pkt_start sets again after accepting a tlast beat.
- Emission:
  - Each edge with stall=0 and rem != 0 registers the lowest set lane of rem into out1, drives t_valid_out1=1 and clears that bit.
  - Kept lanes appear in ascending order: the first element at edge N+1, the j-th kept lane at edge N+j when no stall occurs.
  - Edges without emission drive t_valid_out1=0; out1 holds its value.
- out_last=1 with the element that empties rem when last_flag=1; otherwise 0.
- Throughput: s_axis_tready = (rem==0) || (popcount(rem)==1 && !stall). This gives back-to-back beats with no bubble; a full 8-lane stream sustains 1 element/cycle.
- stall=1: no lane advances, t_valid_out1=0 on the next edge, tready only if the buffer is empty.
- tkeep==0 beat:
  - consumed in one cycle with no output;
  - its tlast still resets pkt_start, but out_last is not emitted;
  - the drop is counted when the optional feature is enabled.
- The op_out change at a packet start takes effect on the same edge as the buffer load, so it is never observed mid-packet.
- Reset mid-DRAIN discards the remaining lanes; there is no partial output after release.

Optional Feature:
- Macro UNPACK_STATS_EN.
- When defined, adds outputs stat_elems[31:0] (elements emitted) and stat_drops[31:0] (tkeep==0 beats). Both are saturating at 32'hFFFF_FFFF and reset to 0 by rst.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package:
  - LANES constant;
  - state enum {IDLE, DRAIN};
  - opcode typedef op_t (2 bits);
  - reuse of the existing dwidth_double.
- One sub-module: lane_prio_enc, a combinational lowest-set-bit encoder from LANES bits to a lane index plus a one-hot clear mask.

Test Plan:
- Full beat: tdata lanes = 64'd1..64'd8, tkeep=8'hFF, tlast=1, cfg_op=2'b01 → out1 = 1..8 on 8 consecutive edges, out_last only with 8, op_out=01 from the accept edge, tready low for 7 cycles.
- Back-to-back: two full beats, tvalid held → 16 elements with no valid gap; second beat accepted on the same edge as element 8 is emitted.
- Sparse mask: tkeep=8'b1010_0100 with lanes valued 100+k → out1 = 102, 105, 107 on consecutive edges, then idle.
- Stall: assert stall for 3 cycles after element 2 of a full beat → t_valid_out1=0 for 3 edges, element 3 follows with no element lost or duplicated, tready stays 0.
- Zero keep then op change: beat tkeep=0, tlast=1, followed by a beat with cfg_op=2'b00 → no output for the first beat, op_out=00 for the second beat; with UNPACK_STATS_EN, stat_drops=1.
- Reset mid-drain: rst low after element 3 of a full beat → outputs 0 immediately; after release tready=1 and no stale elements appear.
